// File: rtl/rede_taylor_core.sv
// rede_taylor_core: cubic Taylor evaluator, y = C0 + C1*x + C2*x^2 + C3*x^3, Horner's rule, one MAC per cycle.
// Latency: sample captured at the end of the REQ cycle, result on io_out during OUT, 4 cycles later; period 5 cycles.
// Backpressure: none; the consumer must take io_out during the single cycle out_en = 4'b0001.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   io_in   signed sample x (Q6.12 with defaults), must be valid at the edge closing the req_in cycle
//   io_out  signed result y, registered, holds until the next OUT cycle
//   req_in  input-port request code (4'b0001 = sample port 0 this cycle)
//   out_en  output-port enable code (4'b0001 = io_out valid on port 0)
module rede_taylor_core #(
  parameter int                 FRAC = 12,
  parameter logic signed [27:0] C0   = 28'sd4096,
  parameter logic signed [27:0] C1   = 28'sd4096,
  parameter logic signed [27:0] C2   = 28'sd2048,
  parameter logic signed [27:0] C3   = 28'sd683
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [18:0] io_in,
  output logic signed [27:0] io_out,
  output logic        [3:0]  req_in,
  output logic        [3:0]  out_en
);

  localparam int PW = 47;         // exact width of a 28x19 signed product
  localparam int SW = PW - FRAC;  // width after the Q-format shift

  localparam logic signed [SW-1:0] SMAX = SW'(134217727);
  localparam logic signed [SW-1:0] SMIN = -SW'(134217728);
  localparam logic signed [28:0]   AMAX = 29'sd134217727;
  localparam logic signed [28:0]   AMIN = -29'sd134217728;

  typedef enum logic [2:0] {
    REQ  = 3'd0,
    MAC2 = 3'd1,
    MAC1 = 3'd2,
    MAC0 = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [18:0]   x_q;
  logic signed [27:0]   acc_q;
  logic signed [27:0]   coef;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] scaled;
  logic signed [27:0]   scaled_sat;
  logic signed [28:0]   sum;
  logic signed [27:0]   mac_res;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and port codes. req_in is gated by rst so that the request
  // code is 0 while reset is held even though the state rests in REQ.
  always_comb begin
    state_d = state_q;
    req_in  = 4'b0000;
    out_en  = 4'b0000;
    coef    = C0;
    case (state_q)
      REQ: begin
        state_d = MAC2;
        if (rst) req_in = 4'b0001;
      end
      MAC2: begin
        state_d = MAC1;
        coef    = C2;
      end
      MAC1: begin
        state_d = MAC0;
        coef    = C1;
      end
      MAC0: begin
        state_d = OUT;
        coef    = C0;
      end
      OUT: begin
        state_d = REQ;
        out_en  = 4'b0001;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // Horner step: acc*x, floor-scaled, saturated, then plus the coefficient
  // and saturated again. Both operands are sign-extended to the full
  // product width so the multiply is exact.
  always_comb begin
    prod   = $signed({{(PW-28){acc_q[27]}}, acc_q}) * $signed({{(PW-19){x_q[18]}}, x_q});
    scaled = SW'(prod >>> FRAC);
    if (scaled > SMAX) begin
      scaled_sat = 28'sh7FFFFFF;
    end else if (scaled < SMIN) begin
      scaled_sat = 28'sh8000000;
    end else begin
      scaled_sat = scaled[27:0];
    end
    sum = {scaled_sat[27], scaled_sat} + {coef[27], coef};
    if (sum > AMAX) begin
      mac_res = 28'sh7FFFFFF;
    end else if (sum < AMIN) begin
      mac_res = 28'sh8000000;
    end else begin
      mac_res = sum[27:0];
    end
  end

  // Datapath registers. io_out is loaded on the MAC0 edge so that it is
  // already valid during the OUT cycle, and is left alone otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      acc_q  <= '0;
      io_out <= '0;
    end else begin
      case (state_q)
        REQ: begin
          x_q   <= io_in;
          acc_q <= C3;
        end
        MAC2, MAC1: begin
          acc_q <= mac_res;
        end
        MAC0: begin
          acc_q  <= mac_res;
          io_out <= mac_res;
        end
        default: begin
          acc_q <= acc_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rede_taylor_core.sv
// tb_rede_taylor_core: directed table plus corner sequences and a random sweep for rede_taylor_core.
// Latency: checks 4-cycle sample-to-result timing and the 5-cycle period.
// Backpressure: none; outputs sampled on the falling edge, inputs driven on the falling edge.
module tb_rede_taylor_core;

  logic               clk;
  logic               rst;
  logic signed [18:0] io_in;
  logic signed [27:0] io_out;
  logic        [3:0]  req_in;
  logic        [3:0]  out_en;

  int checks;
  int errors;

  rede_taylor_core dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .req_in (req_in),
    .out_en (out_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic signed [18:0] x;
    logic signed [27:0] y;
    string              name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat28(input longint v);
    if (v > 134217727) return 134217727;
    if (v < -134217728) return -134217728;
    return v;
  endfunction

  // Reference: default coefficients, floor shift, saturate after scale and after add.
  function automatic longint model(input longint x);
    longint a;
    a = 683;
    a = sat28(sat28((a * x) >>> 12) + 2048);
    a = sat28(sat28((a * x) >>> 12) + 4096);
    a = sat28(sat28((a * x) >>> 12) + 4096);
    return a;
  endfunction

  // Wait for a request, present x for the capture edge, then scramble io_in
  // every cycle and expect out_en exactly 4 cycles later carrying yexp.
  task automatic run_sample(input logic signed [18:0] xv, input longint yexp, input string name);
    int n;
    int lat;
    n = 0;
    while (req_in !== 4'b0001 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_req"}, longint'(req_in), 1);
    io_in = xv;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      io_in = 19'($urandom);
      check({name, "_overlap"}, longint'((req_in != 0) && (out_en != 0)), 0);
      if (out_en == 4'b0001) begin
        lat = c;
        break;
      end
    end
    check({name, "_lat"}, lat, 4);
    check({name, "_y"}, longint'(io_out), yexp);
    @(negedge clk);
    check({name, "_hold"}, longint'(io_out), yexp);
    check({name, "_en_drop"}, longint'(out_en), 0);
  endtask

  initial begin
    logic signed [18:0] xr;
    checks = 0;
    errors = 0;

    vecs[0] = '{x: 19'sd0,       y: 28'sd4096,       name: "zero"};
    vecs[1] = '{x: 19'sd4096,    y: 28'sd10923,      name: "one"};
    vecs[2] = '{x: -19'sd4096,   y: 28'sd1365,       name: "minus_one"};
    vecs[3] = '{x: 19'sd2048,    y: 28'sd6741,       name: "half"};
    vecs[4] = '{x: -19'sd2048,   y: 28'sd2474,       name: "minus_half"};
    vecs[5] = '{x: 19'sd262143,  y: 28'sd134217727,  name: "max_pos"};
    vecs[6] = '{x: -19'sd262144, y: -28'sd134213632, name: "max_neg"};

    // Reset behaviour and first-frame timing
    rst   = 1'b0;
    io_in = '0;
    repeat (3) @(negedge clk);
    check("rst_io_out", longint'(io_out), 0);
    check("rst_req_in", longint'(req_in), 0);
    check("rst_out_en", longint'(out_en), 0);
    rst = 1'b1;
    #1;
    check("c0_req_in", longint'(req_in), 1);
    check("c0_out_en", longint'(out_en), 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("c123_out_en", longint'(out_en), 0);
      check("c123_req_in", longint'(req_in), 0);
    end
    @(negedge clk);
    check("c4_out_en", longint'(out_en), 1);
    check("c4_req_in", longint'(req_in), 0);
    check("c4_io_out", longint'(io_out), 4096);
    @(negedge clk);
    check("c5_req_in", longint'(req_in), 1);
    check("c5_out_en", longint'(out_en), 0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_sample(vecs[i].x, longint'(vecs[i].y), vecs[i].name);
    end

    // Reset asserted in MAC1 discards the partial result
    while (req_in !== 4'b0001) @(negedge clk);
    io_in = 19'sd4096;
    @(negedge clk);
    io_in = 19'sd1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_io_out", longint'(io_out), 0);
    check("midrst_out_en", longint'(out_en), 0);
    check("midrst_req_in", longint'(req_in), 0);
    @(negedge clk);
    io_in = -19'sd4096;
    rst   = 1'b1;
    #1;
    check("midrst_c0_req", longint'(req_in), 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      io_in = 19'($urandom);
      check("midrst_out_en", longint'(out_en), (c == 4) ? 1 : 0);
    end
    check("midrst_y", longint'(io_out), 1365);
    @(negedge clk);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      if (i[0]) xr = 19'($urandom);
      else      xr = 19'($signed($urandom_range(0, 32767)) - 16384);
      run_sample(xr, model(longint'(xr)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/rede_taylor_core.md
Name: rede_taylor_core

Overview:
Single-core Taylor-series evaluator, replicated N times under the multicore wrapper, all sharing one input bus.
- Repeatedly requests a sample x on input port 0.
- Evaluates the cubic polynomial y = C0 + C1·x + C2·x² + C3·x³ in fixed point using Horner's rule, one multiply-accumulate per cycle.
- Presents y on a shared-style output bus, qualified by a port-enable code.

Parameters:
- FRAC, 12, number of fractional bits of x, the coefficients and the result (Q-format shift).
- C0, 4096, 28-bit signed constant term (default 1.0).
- C1, 4096, 28-bit signed linear coefficient (default 1.0).
- C2, 2048, 28-bit signed quadratic coefficient (default 0.5).
- C3, 683, 28-bit signed cubic coefficient (default ≈1/6).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- io_in  input  19  signed sample x (Q6.12 with defaults).
- io_out  output  28  signed result y, registered.
- req_in  output  4  input-port request code; 4'b0001 means "sample io_in port 0 this cycle", 0 means idle.
- out_en  output  4  output-port enable code; 4'b0001 means io_out valid on port 0, 0 means no output.

Behaviour:
- While rst=0: io_out=0, req_in=0, out_en=0, x=0, acc=0, state=REQ.
- All four of those values are cleared asynchronously.
- FSM states: REQ -> MAC2 -> MAC1 -> MAC0 -> OUT -> REQ. One state per cycle; period is 5 cycles.
- REQ:
  - req_in=4'b0001, out_en=0.
  - At the closing edge: x <= io_in and acc <= C3.
  - io_in must be valid at the edge that ends the cycle in which req_in=1.
- MACk (k=2,1,0):
  - Product p = acc·x, exact 47-bit signed.
  - Scale: s = p >>> FRAC (arithmetic shift, floor rounding).
  - Saturate s to 28-bit signed [-2^27, 2^27-1].
  - Then acc <= sat28(s + Ck); the sum is formed at 29 bits and saturated.
  - req_in=0 and out_en=0 in these states.
- OUT:
  - io_out is driven with acc, registered so it is valid during the OUT cycle.
  - out_en=4'b0001 for exactly this one cycle; req_in=0.
- io_out holds its last value until the next OUT cycle; it is not cleared when out_en drops.
- Timing from release of rst (cycle 0 = first clock edge with rst=1):
  - req_in high during cycle 0.
  - out_en high during cycle 4.
  - Next req_in in cycle 5, then steady state.
- Latency: sample to result is 4 cycles.
- req_in and out_en are never both nonzero in the same cycle.
- Codes 4'b0010..4'b1111 are never driven; they are reserved for extra ports.
- Reset asserted mid-computation: the partial result is discarded, outputs are 0 immediately, and the core restarts at REQ after release.
- No backpressure: the consumer must take the result during the out_en cycle.
- The multicore wrapper staggers core resets so cores pulse out_en in different cycles. The core itself has no arbitration.

Test Plan:
- Reset then release, io_in=0 -> req_in=1 in cycle 0; out_en=1 with io_out=4096 in cycle 4; out_en=0 in cycles 0-3; period 5 thereafter.
- io_in=4096 (1.0) -> io_out=10923; intermediates acc=683 -> 2731 -> 6827 -> 10923.
- io_in=-4096 -> io_out=1365; intermediates acc=683 -> 1365 -> 2731 -> 1365.
- io_in=262143 (max positive) -> saturation path; io_out=134217727 (2^27-1). Repeat with io_in=-262144: the result saturates or stays in range per the bit-exact model, never wraps.
- io_in changes every cycle (ramp) -> each result uses only the value present at the end of the req_in cycle. Check against a bit-exact software model over 1000 random samples.
- Drive rst=0 during MAC1 -> io_out, out_en and req_in go to 0 asynchronously. After release, req_in=1 in the first cycle, with no spurious out_en.
